// File: rtl/rx_payload_commit_writer.sv
// Write end of the per-flow RX payload ring: checks free space against head/commit,
// streams payload lines into the RX buffer at the commit pointer, then publishes the new commit.
module rx_payload_commit_writer #(
    parameter int unsigned FLOW_ID_W = 6,
    parameter int unsigned RX_PTR_W  = 14,
    parameter int unsigned DATA_W    = 256,
    parameter int unsigned PAD_W     = 5,
    parameter int unsigned SIZE_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 desc_val,
    output logic                 desc_rdy,
    input  logic [FLOW_ID_W-1:0] desc_flowid,
    input  logic [SIZE_W-1:0]    desc_size,

    input  logic                 data_val,
    output logic                 data_rdy,
    input  logic [DATA_W-1:0]    data,
    input  logic                 data_last,
    input  logic [PAD_W-1:0]     data_padbytes,

    output logic                 ptr_rd_req_val,
    input  logic                 ptr_rd_req_rdy,
    output logic [FLOW_ID_W-1:0] ptr_rd_req_flowid,
    input  logic                 ptr_rd_resp_val,
    input  logic [RX_PTR_W:0]    ptr_rd_resp_head,
    input  logic [RX_PTR_W:0]    ptr_rd_resp_commit,

    output logic                 buf_wr_val,
    input  logic                 buf_wr_rdy,
    output logic [FLOW_ID_W-1:0] buf_wr_flowid,
    output logic [RX_PTR_W:0]    buf_wr_addr,
    output logic [DATA_W-1:0]    buf_wr_data,
    output logic                 buf_wr_last,
    output logic [PAD_W-1:0]     buf_wr_padbytes,

    output logic                 commit_wr_val,
    input  logic                 commit_wr_rdy,
    output logic [FLOW_ID_W-1:0] commit_wr_flowid,
    output logic [RX_PTR_W:0]    commit_wr_data,

    output logic [31:0]          drop_cnt,
    output logic                 busy
);

    localparam int unsigned PtrW      = RX_PTR_W + 1;
    localparam int unsigned DataBytes = DATA_W / 8;
    // Wide enough that used + size can never overflow.
    localparam int unsigned CmpW      = ((SIZE_W > PtrW) ? SIZE_W : PtrW) + 1;
    localparam logic [CmpW-1:0] RingBytes = CmpW'(1) << RX_PTR_W;
    localparam logic [PtrW-1:0] LineStep  = PtrW'(DataBytes);

    typedef enum logic [2:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StCheck,
        StWrite,
        StDrop,
        StCommit
    } state_e;

    state_e                 state_q, state_d;
    logic [FLOW_ID_W-1:0]   flowid_q, flowid_d;
    logic [SIZE_W-1:0]      size_q, size_d;
    logic [PtrW-1:0]        head_q, head_d;
    logic [PtrW-1:0]        commit_q, commit_d;
    logic [PtrW-1:0]        offset_q, offset_d;
    logic [31:0]            drop_cnt_q, drop_cnt_d;

    logic [PtrW-1:0]        used;
    logic                   has_room;

    // Wrap-bit pointers: the modular difference is the occupancy even across a wrap.
    assign used     = commit_q - head_q;
    assign has_room = (CmpW'(used) + CmpW'(size_q)) <= RingBytes;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            flowid_q   <= '0;
            size_q     <= '0;
            head_q     <= '0;
            commit_q   <= '0;
            offset_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            flowid_q   <= flowid_d;
            size_q     <= size_d;
            head_q     <= head_d;
            commit_q   <= commit_d;
            offset_q   <= offset_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        flowid_d       = flowid_q;
        size_d         = size_q;
        head_d         = head_q;
        commit_d       = commit_q;
        offset_d       = offset_q;
        drop_cnt_d     = drop_cnt_q;
        desc_rdy       = 1'b0;
        ptr_rd_req_val = 1'b0;
        buf_wr_val     = 1'b0;
        data_rdy       = 1'b0;
        commit_wr_val  = 1'b0;

        unique case (state_q)
            StIdle: begin
                desc_rdy = 1'b1;
                if (desc_val) begin
                    flowid_d = desc_flowid;
                    size_d   = desc_size;
                    state_d  = StRdReq;
                end
            end
            StRdReq: begin
                ptr_rd_req_val = 1'b1;
                if (ptr_rd_req_rdy) begin
                    state_d = StRdWait;
                end
            end
            StRdWait: begin
                if (ptr_rd_resp_val) begin
                    head_d   = ptr_rd_resp_head;
                    commit_d = ptr_rd_resp_commit;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (size_q == '0) begin
                    state_d = StIdle;
                end else if (has_room) begin
                    offset_d = commit_q;
                    state_d  = StWrite;
                end else begin
                    state_d = StDrop;
                end
            end
            StWrite: begin
                buf_wr_val = data_val;
                data_rdy   = buf_wr_rdy;
                if (data_val && buf_wr_rdy) begin
                    offset_d = offset_q + LineStep;
                    if (data_last) begin
                        state_d = StCommit;
                    end
                end
            end
            StDrop: begin
                data_rdy = 1'b1;
                if (data_val && data_last) begin
                    if (drop_cnt_q != '1) begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                    end
                    state_d = StIdle;
                end
            end
            StCommit: begin
                commit_wr_val = 1'b1;
                if (commit_wr_rdy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign ptr_rd_req_flowid = flowid_q;
    assign buf_wr_flowid     = flowid_q;
    assign buf_wr_addr       = offset_q;
    assign buf_wr_data       = data;
    assign buf_wr_last       = data_last;
    assign buf_wr_padbytes   = data_padbytes;
    assign commit_wr_flowid  = flowid_q;
    // Commit advances by the descriptor size regardless of how many lines arrived.
    assign commit_wr_data    = commit_q + PtrW'(size_q);
    assign drop_cnt          = drop_cnt_q;
    assign busy              = (state_q != StIdle);

endmodule

// File: tb/tb_rx_payload_commit_writer.sv
// Scoreboard bench for rx_payload_commit_writer: directed payloads push expected buffer
// writes and commits; a monitor pops and compares whenever the DUT presents them.
module tb_rx_payload_commit_writer;

    logic         clk = 1'b0;
    logic         rst;
    logic         desc_val;
    logic         desc_rdy;
    logic [5:0]   desc_flowid;
    logic [15:0]  desc_size;
    logic         data_val;
    logic         data_rdy;
    logic [255:0] data;
    logic         data_last;
    logic [4:0]   data_padbytes;
    logic         ptr_rd_req_val;
    logic         ptr_rd_req_rdy;
    logic [5:0]   ptr_rd_req_flowid;
    logic         ptr_rd_resp_val;
    logic [14:0]  ptr_rd_resp_head;
    logic [14:0]  ptr_rd_resp_commit;
    logic         buf_wr_val;
    logic         buf_wr_rdy;
    logic [5:0]   buf_wr_flowid;
    logic [14:0]  buf_wr_addr;
    logic [255:0] buf_wr_data;
    logic         buf_wr_last;
    logic [4:0]   buf_wr_padbytes;
    logic         commit_wr_val;
    logic         commit_wr_rdy;
    logic [5:0]   commit_wr_flowid;
    logic [14:0]  commit_wr_data;
    logic [31:0]  drop_cnt;
    logic         busy;

    rx_payload_commit_writer dut (
        .clk                (clk),
        .rst                (rst),
        .desc_val           (desc_val),
        .desc_rdy           (desc_rdy),
        .desc_flowid        (desc_flowid),
        .desc_size          (desc_size),
        .data_val           (data_val),
        .data_rdy           (data_rdy),
        .data               (data),
        .data_last          (data_last),
        .data_padbytes      (data_padbytes),
        .ptr_rd_req_val     (ptr_rd_req_val),
        .ptr_rd_req_rdy     (ptr_rd_req_rdy),
        .ptr_rd_req_flowid  (ptr_rd_req_flowid),
        .ptr_rd_resp_val    (ptr_rd_resp_val),
        .ptr_rd_resp_head   (ptr_rd_resp_head),
        .ptr_rd_resp_commit (ptr_rd_resp_commit),
        .buf_wr_val         (buf_wr_val),
        .buf_wr_rdy         (buf_wr_rdy),
        .buf_wr_flowid      (buf_wr_flowid),
        .buf_wr_addr        (buf_wr_addr),
        .buf_wr_data        (buf_wr_data),
        .buf_wr_last        (buf_wr_last),
        .buf_wr_padbytes    (buf_wr_padbytes),
        .commit_wr_val      (commit_wr_val),
        .commit_wr_rdy      (commit_wr_rdy),
        .commit_wr_flowid   (commit_wr_flowid),
        .commit_wr_data     (commit_wr_data),
        .drop_cnt           (drop_cnt),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [14:0]  addr;
        logic [255:0] data;
        logic         last;
        logic [4:0]   pad;
        logic [5:0]   fid;
    } line_t;

    typedef struct {
        logic [5:0]  fid;
        logic [14:0] data;
    } cmt_t;

    line_t line_q[$];
    cmt_t  cmt_q[$];

    int          nvec = 0;
    int          nerr = 0;
    logic [5:0]  exp_fid;
    logic [14:0] resp_head;
    logic [14:0] resp_commit;
    bit          bp_mode;
    int          commit_stall;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] rand_line();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
        return r;
    endfunction

    task automatic drive_line(input logic [255:0] d, input bit last, input logic [4:0] pad);
        data          = d;
        data_last     = last;
        data_padbytes = pad;
        data_val      = 1'b1;
    endtask

    // Pointer responder: answers each accepted request one cycle later.
    initial begin
        logic seen;
        ptr_rd_resp_val    = 1'b0;
        ptr_rd_resp_head   = '0;
        ptr_rd_resp_commit = '0;
        forever begin
            @(negedge clk);
            seen = ptr_rd_req_val && ptr_rd_req_rdy && !rst;
            if (seen) chk("ptr_req_flowid", ptr_rd_req_flowid, exp_fid);
            @(posedge clk);
            #1;
            ptr_rd_resp_val    = seen;
            ptr_rd_resp_head   = resp_head;
            ptr_rd_resp_commit = resp_commit;
        end
    end

    initial begin
        buf_wr_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            buf_wr_rdy = bp_mode ? ~buf_wr_rdy : 1'b1;
        end
    end

    initial begin
        int left;
        left          = 0;
        commit_wr_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (commit_wr_val && left > 0) begin
                commit_wr_rdy = 1'b0;
                left--;
            end else begin
                commit_wr_rdy = 1'b1;
                if (!commit_wr_val) left = commit_stall;
            end
        end
    end

    // Monitor: pops expectations on each handshake, checks hold-steady while stalled.
    initial begin
        line_t        e;
        cmt_t         c;
        logic         bstall, cstall;
        logic [14:0]  s_addr, s_cdata;
        logic [255:0] s_data;
        logic [5:0]   s_cfid;
        bstall = 1'b0;
        cstall = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bstall = 1'b0;
                cstall = 1'b0;
            end else begin
                if (bstall && buf_wr_val) begin
                    chk("buf_addr_hold", buf_wr_addr, s_addr);
                    chk("buf_data_hold", buf_wr_data, s_data);
                end
                if (buf_wr_val && buf_wr_rdy) begin
                    if (line_q.size() == 0) begin
                        chk("buf_wr_unexpected", buf_wr_val, 1'b0);
                    end else begin
                        e = line_q.pop_front();
                        chk("buf_wr_addr", buf_wr_addr, e.addr);
                        chk("buf_wr_data", buf_wr_data, e.data);
                        chk("buf_wr_last", buf_wr_last, e.last);
                        chk("buf_wr_pad", buf_wr_padbytes, e.pad);
                        chk("buf_wr_flowid", buf_wr_flowid, e.fid);
                    end
                end
                bstall = buf_wr_val && !buf_wr_rdy;
                s_addr = buf_wr_addr;
                s_data = buf_wr_data;

                if (cstall && commit_wr_val) begin
                    chk("commit_data_hold", commit_wr_data, s_cdata);
                    chk("commit_fid_hold", commit_wr_flowid, s_cfid);
                end
                if (commit_wr_val && commit_wr_rdy) begin
                    if (cmt_q.size() == 0) begin
                        chk("commit_wr_unexpected", commit_wr_val, 1'b0);
                    end else begin
                        c = cmt_q.pop_front();
                        chk("commit_wr_data", commit_wr_data, c.data);
                        chk("commit_wr_flowid", commit_wr_flowid, c.fid);
                    end
                end
                cstall  = commit_wr_val && !commit_wr_rdy;
                s_cdata = commit_wr_data;
                s_cfid  = commit_wr_flowid;
            end
        end
    end

    // exp_cyc: cycle (counted from acceptance) in which desc_rdy returns; 0 skips the check.
    task automatic run_payload(input logic [5:0] fid, input logic [15:0] size,
                               input logic [14:0] head, input logic [14:0] cmt,
                               input int nlines, input bit exp_wr,
                               input logic [14:0] exp_cmt, input int exp_cyc);
        logic [255:0] ld[8];
        logic [4:0]   pad_last;
        int           n, li;
        bit           hs, done;
        pad_last = 5'(nlines * 32 - int'(size));
        for (int i = 0; i < nlines; i++) begin
            ld[i] = rand_line();
            if (exp_wr) line_q.push_back('{addr: cmt + 15'(32 * i), data: ld[i],
                                           last: (i == nlines - 1),
                                           pad: (i == nlines - 1) ? pad_last : 5'd0,
                                           fid: fid});
        end
        if (exp_wr) cmt_q.push_back('{fid: fid, data: exp_cmt});
        @(posedge clk);
        #1;
        exp_fid     = fid;
        resp_head   = head;
        resp_commit = cmt;
        desc_val    = 1'b1;
        desc_flowid = fid;
        desc_size   = size;
        @(negedge clk);
        chk("desc_rdy_idle", desc_rdy, 1'b1);
        @(posedge clk);
        #1;
        desc_val = 1'b0;
        li = 0;
        if (nlines > 0) drive_line(ld[0], nlines == 1, (nlines == 1) ? pad_last : 5'd0);
        n    = 0;
        done = 1'b0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) chk("ptr_req_latency", ptr_rd_req_val, 1'b1);
            if (desc_rdy) begin
                done = 1'b1;
            end else begin
                hs = data_val && data_rdy;
                @(posedge clk);
                #1;
                if (hs) begin
                    li++;
                    if (li < nlines) drive_line(ld[li], li == nlines - 1,
                                                (li == nlines - 1) ? pad_last : 5'd0);
                    else data_val = 1'b0;
                end
            end
        end
        chk("payload_done", done, 1'b1);
        chk("lines_consumed", li, nlines);
        if (exp_cyc > 0) chk("desc_to_desc_cycles", n, exp_cyc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [255:0] ld;
        int           n;
        rst            = 1'b1;
        desc_val       = 1'b0;
        desc_flowid    = '0;
        desc_size      = '0;
        data_val       = 1'b0;
        data           = '0;
        data_last      = 1'b0;
        data_padbytes  = '0;
        ptr_rd_req_rdy = 1'b1;
        exp_fid        = '0;
        resp_head      = '0;
        resp_commit    = '0;
        bp_mode        = 1'b0;
        commit_stall   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_desc_rdy", desc_rdy, 1'b1);
        chk("rst_data_rdy", data_rdy, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_ptr_req_val", ptr_rd_req_val, 1'b0);
        chk("rst_commit_val", commit_wr_val, 1'b0);
        chk("rst_drop_cnt", drop_cnt, 32'd0);

        // Empty ring, two lines.
        run_payload(6'h05, 16'd64, 15'h0000, 15'h0000, 2, 1'b1, 15'h0040, 7);
        // Single line, minimum descriptor interval.
        run_payload(6'h11, 16'd32, 15'h0100, 15'h0200, 1, 1'b1, 15'h0220, 6);
        // Address wraps into the wrap-bit half.
        run_payload(6'h2A, 16'd64, 15'h3FE0, 15'h3FE0, 2, 1'b1, 15'h4020, 7);
        // Exactly 32 bytes free.
        run_payload(6'h03, 16'd32, 15'h0000, 15'h3FE0, 1, 1'b1, 15'h4000, 6);
        // One byte too many: drained and dropped.
        run_payload(6'h03, 16'd33, 15'h0000, 15'h3FE0, 2, 1'b0, 15'h0000, 6);
        chk("drop_cnt_1", drop_cnt, 32'd1);
        // Full ring distinguished only by the wrap bit.
        run_payload(6'h04, 16'd32, 15'h0010, 15'h4010, 1, 1'b0, 15'h0000, 5);
        chk("drop_cnt_2", drop_cnt, 32'd2);
        // Commit wrapped past head's MSB: used = 32.
        run_payload(6'h3F, 16'd64, 15'h7FF0, 15'h0010, 2, 1'b1, 15'h0050, 7);
        // Zero-size descriptor.
        run_payload(6'h07, 16'd0, 15'h0040, 15'h0080, 0, 1'b0, 15'h0000, 4);

        // Backpressure on both buffer and commit writes.
        bp_mode      = 1'b1;
        commit_stall = 3;
        run_payload(6'h15, 16'd96, 15'h0100, 15'h0200, 3, 1'b1, 15'h0260, 0);
        bp_mode      = 1'b0;
        commit_stall = 0;
        chk("drop_cnt_after_bp", drop_cnt, 32'd2);

        // Reset after the first of three lines.
        @(posedge clk);
        #1;
        exp_fid     = 6'h09;
        resp_head   = 15'h0000;
        resp_commit = 15'h1000;
        ld          = rand_line();
        line_q.push_back('{addr: 15'h1000, data: ld, last: 1'b0, pad: 5'd0, fid: 6'h09});
        desc_val    = 1'b1;
        desc_flowid = 6'h09;
        desc_size   = 16'd96;
        @(negedge clk);
        chk("rstmid_desc_rdy", desc_rdy, 1'b1);
        @(posedge clk);
        #1;
        desc_val = 1'b0;
        drive_line(ld, 1'b0, 5'd0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_rdy && n < 50);
        chk("rstmid_first_line", data_rdy, 1'b1);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        data_val = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_commit_val", commit_wr_val, 1'b0);
        chk("rstmid_ptr_req_val", ptr_rd_req_val, 1'b0);
        chk("rstmid_buf_wr_val", buf_wr_val, 1'b0);
        chk("rstmid_drop_cnt", drop_cnt, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_desc_rdy_after", desc_rdy, 1'b1);
        chk("rstmid_data_rdy", data_rdy, 1'b0);

        run_payload(6'h21, 16'd40, 15'h1000, 15'h1000, 2, 1'b1, 15'h1028, 7);
        chk("drop_cnt_final", drop_cnt, 32'd0);

        repeat (5) @(negedge clk);
        chk("line_q_drained", line_q.size(), 0);
        chk("commit_q_drained", cmt_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rx_payload_commit_writer.md
# rx_payload_commit_writer

Receive-side producer for the per-flow RX payload ring. It accepts a payload descriptor and its data lines from the RX packet pipeline, and reads the flow's RX head and commit pointers. If the ring has room, it writes the payload into the RX buffer at the commit pointer and then publishes the new commit pointer. The application datapath reads the ring from the head pointer and advances the head pointer; this block is the write end of that head/commit protocol. If the ring lacks space, the payload is drained and dropped.

## Interface
- FLOW_ID_W, 6, flow id width
- RX_PTR_W, 14, log2 of RX ring bytes; pointers are RX_PTR_W+1 bits (MSB = wrap bit)
- DATA_W, 256, data line width; DATA_BYTES = DATA_W/8 = 32
- PAD_W, 5, log2(DATA_BYTES)
- SIZE_W, 16, payload size width (bytes)

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- desc_val / desc_rdy  in/out  1  payload descriptor handshake
- desc_flowid  in  FLOW_ID_W  flow of payload
- desc_size  in  SIZE_W  payload bytes
- data_val / data_rdy  in/out  1  payload line handshake
- data  in  DATA_W  payload line
- data_last  in  1  final line
- data_padbytes  in  PAD_W  invalid bytes in final line
- ptr_rd_req_val / ptr_rd_req_rdy  out/in  1  head+commit pointer read request
- ptr_rd_req_flowid  out  FLOW_ID_W  flow to read
- ptr_rd_resp_val  in  1  pointer response valid (always accepted)
- ptr_rd_resp_head  in  RX_PTR_W+1  rx head pointer
- ptr_rd_resp_commit  in  RX_PTR_W+1  rx commit pointer
- buf_wr_val / buf_wr_rdy  out/in  1  RX buffer line write
- buf_wr_flowid  out  FLOW_ID_W  flow
- buf_wr_addr  out  RX_PTR_W+1  byte offset of line
- buf_wr_data  out  DATA_W  line data (= data)
- buf_wr_last  out  1  = data_last
- buf_wr_padbytes  out  PAD_W  = data_padbytes
- commit_wr_val / commit_wr_rdy  out/in  1  commit pointer update
- commit_wr_flowid  out  FLOW_ID_W  flow
- commit_wr_data  out  RX_PTR_W+1  new commit pointer
- drop_cnt  out  32  payloads dropped for lack of space
- busy  out  1  state != IDLE

## Operation
- States: IDLE, RD_REQ, RD_WAIT, CHECK, WRITE, DROP, COMMIT.
- IDLE: desc_rdy=1. On desc_val, latch flowid and size, then go to RD_REQ.
- RD_REQ: ptr_rd_req_val=1. On ptr_rd_req_rdy, go to RD_WAIT.
- RD_WAIT: on ptr_rd_resp_val, latch head and commit, then go to CHECK.
- CHECK: used = commit - head, modulo 2^(RX_PTR_W+1); free = 2^RX_PTR_W - used.
  - size==0: go to IDLE. No data is consumed and no commit write is issued.
  - free >= size: go to WRITE, with line offset = commit.
  - Otherwise: go to DROP.
- WRITE: buf_wr_val = data_val and data_rdy = buf_wr_rdy (combinational pass-through).
  - buf_wr_addr = offset. Each accepted line adds DATA_BYTES to offset, wrapping mod 2^(RX_PTR_W+1).
  - The accepted line with data_last goes to COMMIT.
- COMMIT: commit_wr_val=1, commit_wr_data = latched commit + size (mod 2^(RX_PTR_W+1)). On commit_wr_rdy, go to IDLE.
- DROP: data_rdy=1 and nothing is written. On the accepted data_last line, increment drop_cnt (saturating at 2^32-1) and go to IDLE.
- data_last is authoritative for the end of payload. A mismatch between line count and size does not change the flow; the commit still advances by desc_size.
- Outputs held constant while val is high and rdy is low.
- The ring's physical byte address is the pointer's low RX_PTR_W bits. The full wrap-bit pointer is emitted; the buffer discards the MSB.

## Timing
- Reset: state=IDLE, drop_cnt=0, all latched regs 0, every val output 0. desc_rdy=1 in the first cycle after reset. data_rdy=0, busy=0.
- A descriptor accepted in cycle N gives ptr_rd_req_val in N+1.
- A response in cycle M gives CHECK in M+1, and the first buf_wr_val is possible in M+2.
- Data lines stream at 1 line/cycle when buf_wr_rdy=1, with zero added latency.
- COMMIT is entered the cycle after the last line handshake. IDLE returns the cycle after the commit_wr handshake.
- Minimum descriptor-to-descriptor interval with a single-line payload and all rdys high and a 1-cycle response: 6 cycles.
- data_val before WRITE/DROP is held off (data_rdy=0).
- rst mid-operation: next cycle is IDLE with all vals low. Partial writes are not committed, because the commit pointer is never updated.

## Test plan
- Empty ring: head=0, commit=0, size=64, 2 lines -> buf_wr_addr 0 then 32, buf_wr_last on second; commit_wr_data=64.
- Wrap: RX_PTR_W=14, head=0x3FE0, commit=0x3FE0, size=64 -> addrs 0x3FE0, 0x4000; commit_wr_data=0x4020.
- Exact fit: used=16352 (free 32), size=32 -> written and committed. With size=33 -> DROP, 2 lines drained with data_rdy=1, no buf_wr_val, drop_cnt=1.
- Backpressure: buf_wr_rdy toggling 1/0, commit_wr_rdy low 3 cycles -> addresses, data and commit_wr_data stable while stalled; no lines lost or duplicated.
- size=0 descriptor -> no ptr-driven write, no commit_wr_val, desc_rdy again 4 cycles after acceptance with a 1-cycle response.
- rst asserted during WRITE after 1 of 3 lines -> vals low next cycle, no commit_wr; a following descriptor processes normally with drop_cnt=0.
